// File: rtl/periph_mmio_v2.sv
// Memory-mapped peripheral block: reload timers, LED/switch/7-seg GPIO, UART TX request and
// an RX byte FIFO with pop-on-read, all behind one 0x60-byte register window.
module periph_mmio_v2 #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned SW_W       = 8,
  parameter int unsigned DIGI_W     = 12,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned TX_HOLD    = 326
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_status,
  input  logic              rx_status,
  input  logic [7:0]        rx_data
);

  localparam int unsigned PtrW   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned RxCntW = PtrW + 1;
  localparam int unsigned CntW   = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  // Address decode
  logic [31:0] off;
  logic        in_win;
  logic        tmr_hit;
  logic [1:0]  tmr_idx;
  logic [1:0]  tmr_sub;
  logic        sel_led, sel_sw, sel_digi, sel_txd, sel_rxd, sel_ustat;

  assign off       = addr - BASE_ADDR;
  assign in_win    = (addr >= BASE_ADDR) && (off < 32'h60) && (off[1:0] == 2'b00);
  assign tmr_idx   = off[5:4];
  assign tmr_sub   = off[3:2];
  assign tmr_hit   = in_win && (off < 32'h40) && (32'(tmr_idx) < NUM_TIMERS);
  assign sel_led   = in_win && (off == 32'h40);
  assign sel_sw    = in_win && (off == 32'h44);
  assign sel_digi  = in_win && (off == 32'h48);
  assign sel_txd   = in_win && (off == 32'h4C);
  assign sel_rxd   = in_win && (off == 32'h50);
  assign sel_ustat = in_win && (off == 32'h54);

  // Timers
  logic [NUM_TIMERS-1:0][31:0] tmr_rdata;
  logic [NUM_TIMERS-1:0]       pend;
  logic [31:0]                 tmr_rd_or;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        sel, wr_th, wr_tl, wr_tcon;

    assign sel     = tmr_hit && (tmr_idx == 2'(i));
    assign wr_th   = wr && sel && (tmr_sub == 2'd0);
    assign wr_tl   = wr && sel && (tmr_sub == 2'd1);
    assign wr_tcon = wr && sel && (tmr_sub == 2'd2);

    always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      if (wr_th) th_d = wdata;
      // A CPU write to TL or TCON wins over the counting/reload of that cycle.
      if (wr_tl || wr_tcon) begin
        if (wr_tl)   tl_d   = wdata;
        if (wr_tcon) tcon_d = wdata[2:0];
      end else if (tcon_q[0]) begin
        if (tl_q == 32'hFFFF_FFFF) begin
          tl_d = th_q;
          if (tcon_q[1]) tcon_d[2] = 1'b1;
        end else begin
          tl_d = tl_q + 32'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        th_q   <= '0;
        tl_q   <= '0;
        tcon_q <= '0;
      end else begin
        th_q   <= th_d;
        tl_q   <= tl_d;
        tcon_q <= tcon_d;
      end
    end

    assign pend[i]      = tcon_q[2];
    assign tmr_rdata[i] = !sel                ? 32'd0 :
                          (tmr_sub == 2'd0)   ? th_q  :
                          (tmr_sub == 2'd1)   ? tl_q  :
                          (tmr_sub == 2'd2)   ? {29'd0, tcon_q} : 32'd0;
  end

  always_comb begin
    tmr_rd_or = '0;
    for (int i = 0; i < NUM_TIMERS; i++) tmr_rd_or = tmr_rd_or | tmr_rdata[i];
  end

  assign irqout = |pend;

  // GPIO
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;

  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (wr && sel_led)  led_d  = wdata[LED_W-1:0];
    if (wr && sel_digi) digi_d = wdata[DIGI_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

  // UART TX request: tx_en held for TX_HOLD cycles after an accepted TXD write
  logic [7:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    txd_d    = txd_q;
    tx_en_d  = tx_en_q;
    tx_cnt_d = tx_cnt_q;
    if (wr && sel_txd) begin
      txd_d    = wdata[7:0];
      tx_cnt_d = '0;
      tx_en_d  = tx_status;
    end else if (tx_en_q) begin
      if (tx_cnt_q == CntW'(TX_HOLD - 1)) tx_en_d = 1'b0;
      else                                tx_cnt_d = tx_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q    <= '0;
      tx_en_q  <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = txd_q;

  // RX FIFO
  logic [7:0]        fifo_q [RX_DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push;

  assign full = (rx_cnt_q == RxCntW'(RX_DEPTH));
  assign pop  = rd && sel_rxd && (rx_cnt_q != '0);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push = rx_status && (!full || pop);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rx_cnt_d = rx_cnt_q + RxCntW'(push) - RxCntW'(pop);
    ovf_d    = ovf_q;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    if (wr && sel_ustat && wdata[1]) ovf_d = 1'b0;
    if (rx_status && full && !pop)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wptr_q] <= rx_data;
  end

  // Read mux
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (tmr_hit) begin
        rdata = tmr_rd_or;
      end else if (sel_led) begin
        rdata = 32'(led_q);
      end else if (sel_sw) begin
        rdata = 32'(switch);
      end else if (sel_digi) begin
        rdata = 32'(digi_q);
      end else if (sel_txd) begin
        rdata = {24'd0, txd_q};
      end else if (sel_rxd) begin
        rdata = (rx_cnt_q != '0) ? {24'd0, fifo_q[rptr_q]} : 32'd0;
      end else if (sel_ustat) begin
        rdata = {23'd0, 5'(rx_cnt_q), 1'b0, tx_en_q, ovf_q, (rx_cnt_q != '0)};
      end
    end
  end

endmodule

// File: tb/tb_periph_mmio_v2.sv
// Directed and randomized bench for periph_mmio_v2 against a queue/array reference model.
module tb_periph_mmio_v2;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int NT    = 2;
  localparam int LW    = 8;
  localparam int SWW   = 8;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int HOLD  = 326;
  localparam logic [31:0] LED_MASK  = 32'h0000_00FF;
  localparam logic [31:0] DIGI_MASK = 32'h0000_0FFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd, wr;
  logic [31:0]   addr, wdata, rdata;
  logic [LW-1:0] led;
  logic [SWW-1:0] sw;
  logic [DW-1:0] digi;
  logic          irqout, tx_en, tx_status, rx_status;
  logic [7:0]    tx_data, rx_data;

  periph_mmio_v2 #(
    .BASE_ADDR (BASE),
    .NUM_TIMERS(NT),
    .LED_W     (LW),
    .SW_W      (SWW),
    .DIGI_W    (DW),
    .RX_DEPTH  (DEPTH),
    .TX_HOLD   (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .led      (led),
    .switch   (sw),
    .digi     (digi),
    .irqout   (irqout),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_status(tx_status),
    .rx_status(rx_status),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_th [NT];
  logic [31:0] m_tl [NT];
  logic [2:0]  m_tcon [NT];
  logic [31:0] m_led, m_digi;
  logic [7:0]  m_txd;
  int          m_txleft;
  bit          m_ovf;
  logic [7:0]  m_q[$];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    logic [31:0] o;
    if (a < BASE) return -1;
    o = a - BASE;
    if (o >= 32'h60 || o[1:0] != 2'b00) return -1;
    return int'(o);
  endfunction

  function automatic logic [31:0] mread(input logic r, input logic [31:0] a);
    int o = decode(a);
    if (!r || o < 0) return 32'd0;
    if (o < 'h40) begin
      if (o / 16 >= NT) return 32'd0;
      case (o % 16)
        0:       return m_th[o / 16];
        4:       return m_tl[o / 16];
        8:       return {29'd0, m_tcon[o / 16]};
        default: return 32'd0;
      endcase
    end
    case (o)
      'h40: return m_led;
      'h44: return {24'd0, sw};
      'h48: return m_digi;
      'h4C: return {24'd0, m_txd};
      'h50: return (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0;
      'h54: return (m_q.size() << 4) | ((m_txleft > 0) ? 4 : 0) | (m_ovf ? 2 : 0) |
                   ((m_q.size() > 0) ? 1 : 0);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_tcon[i] = '0;
    end
    m_led = '0; m_digi = '0; m_txd = '0; m_txleft = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic rxs, input logic [7:0] rxd,
                            input logic txs);
    int o = decode(a);
    int sz = m_q.size();
    bit popped;
    for (int i = 0; i < NT; i++) begin
      bit w_th = w && (o == 16 * i);
      bit w_tl = w && (o == 16 * i + 4);
      bit w_tc = w && (o == 16 * i + 8);
      if (w_tl || w_tc) begin
        if (w_tl) m_tl[i] = wd;
        if (w_tc) m_tcon[i] = wd[2:0];
      end else if (m_tcon[i][0]) begin
        if (m_tl[i] == 32'hFFFF_FFFF) begin
          m_tl[i] = m_th[i];
          if (m_tcon[i][1]) m_tcon[i][2] = 1'b1;
        end else begin
          m_tl[i] = m_tl[i] + 1;
        end
      end
      if (w_th) m_th[i] = wd;
    end
    if (w && o == 'h40) m_led = wd & LED_MASK;
    if (w && o == 'h48) m_digi = wd & DIGI_MASK;
    if (w && o == 'h4C) begin
      m_txd = wd[7:0];
      m_txleft = txs ? HOLD : 0;
    end else if (m_txleft > 0) begin
      m_txleft--;
    end
    popped = r && (o == 'h50) && (sz > 0);
    if (popped) void'(m_q.pop_front());
    if (w && o == 'h54 && wd[1]) m_ovf = 0;
    if (rxs) begin
      if (sz == DEPTH && !popped) m_ovf = 1;
      else m_q.push_back(rxd);
    end
  endtask

  task automatic check_outs();
    logic any_pend = 1'b0;
    for (int i = 0; i < NT; i++) any_pend |= m_tcon[i][2];
    chk("led", 32'(led), m_led);
    chk("digi", 32'(digi), m_digi);
    chk("irqout", 32'(irqout), 32'(any_pend));
    chk("tx_en", 32'(tx_en), 32'(m_txleft > 0));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
  endtask

  // One bus cycle: drive, check combinational read before the edge, step model, check after
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic rxs, input logic [7:0] rxd, input logic txs);
    rd = r; wr = w; addr = a; wdata = wd;
    rx_status = rxs; rx_data = rxd; tx_status = txs;
    #1;
    chk("rdata", rdata, mread(r, a));
    last_rd = rdata;
    @(posedge clk);
    model_step(r, w, a, wd, rxs, rxd, txs);
    #1;
    check_outs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] d);
    cyc(1'b0, 1'b1, BASE + off, d, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic rd32(input logic [31:0] off);
    cyc(1'b1, 1'b0, BASE + off, 32'd0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0;
    rx_status = 0; rx_data = 0; tx_status = 1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    check_outs();
  endtask

  logic [31:0] raddrs [16] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h30, 32'h40,
                               32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h02,
                               32'h100};

  initial begin
    int hi;
    sw = 8'h3C;
    do_reset();
    rd32(32'h54);
    chk("ustat_reset", last_rd, 32'h0);
    rd32(32'h44);
    chk("switch_rd", last_rd, 32'h3C);

    // Timer0 reload and pending
    wr32(32'h00, 32'hFFFF_FFFD);
    wr32(32'h04, 32'hFFFF_FFFE);
    wr32(32'h08, 32'h3);
    idle();
    idle();
    chk("t0_irq_set", 32'(irqout), 32'h1);
    rd32(32'h04);
    chk("t0_tl_reload", last_rd, 32'hFFFF_FFFD);
    wr32(32'h08, 32'h3);
    chk("t0_irq_clr", 32'(irqout), 32'h0);
    wr32(32'h08, 32'h0);
    rd32(32'h14);
    chk("t1_idle", last_rd, 32'h0);

    // Timer1 pending set collides with a TCON write
    wr32(32'h10, 32'h0);
    wr32(32'h14, 32'hFFFF_FFFE);
    wr32(32'h18, 32'h3);
    idle();
    wr32(32'h18, 32'h1);
    rd32(32'h18);
    chk("t1_tcon_wins", last_rd, 32'h1);
    chk("t1_no_irq", 32'(irqout), 32'h0);
    wr32(32'h18, 32'h0);

    // TX hold window
    cyc(1'b0, 1'b1, BASE + 32'h4C, 32'hA5, 1'b0, 8'd0, 1'b1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    hi = 0;
    for (int k = 0; k < 400 && tx_en; k++) begin
      hi++;
      idle();
    end
    chk("tx_hold_len", 32'(hi), 32'(HOLD));
    cyc(1'b0, 1'b1, BASE + 32'h4C, 32'h5A, 1'b0, 8'd0, 1'b0);
    chk("tx_dropped", 32'(tx_en), 32'h0);
    idle();

    // FIFO overflow and drain
    for (int b = 1; b <= 5; b++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 8'(b), 1'b1);
    rd32(32'h54);
    chk("ustat_full_ovf", last_rd, 32'h43);
    for (int b = 1; b <= 5; b++) begin
      rd32(32'h50);
      chk("rxd_drain", last_rd, (b <= 4) ? 32'(b) : 32'h0);
    end
    wr32(32'h54, 32'h2);
    rd32(32'h54);
    chk("ustat_ovf_clr", last_rd, 32'h0);

    // Push and pop together on a full FIFO
    for (int b = 0; b < 4; b++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 8'h11 + 8'(b), 1'b1);
    cyc(1'b1, 1'b0, BASE + 32'h50, 32'd0, 1'b1, 8'h77, 1'b1);
    chk("rxd_head_on_full", last_rd, 32'h11);
    rd32(32'h54);
    chk("ustat_no_ovf", last_rd, 32'h41);
    for (int b = 0; b < 4; b++) rd32(32'h50);
    chk("rxd_last_77", last_rd, 32'h77);
    // Push and pop together on an empty FIFO
    cyc(1'b1, 1'b0, BASE + 32'h50, 32'd0, 1'b1, 8'h3E, 1'b1);
    chk("rxd_empty_pop", last_rd, 32'h0);
    rd32(32'h50);
    chk("rxd_stored", last_rd, 32'h3E);

    // GPIO and unmapped space
    wr32(32'h40, 32'h1FF);
    chk("led_ff", 32'(led), 32'hFF);
    rd32(32'h40);
    chk("led_rb", last_rd, 32'hFF);
    wr32(32'h58, 32'hFFFF_FFFF);
    rd32(32'h58);
    chk("unmapped_58", last_rd, 32'h0);
    wr32(32'h30, 32'h1234);
    rd32(32'h30);
    chk("timer_slot3", last_rd, 32'h0);

    // Reset in the middle of a transmit
    cyc(1'b0, 1'b1, BASE + 32'h4C, 32'hC3, 1'b0, 8'd0, 1'b1);
    idle();
    idle();
    do_reset();
    chk("tx_en_after_reset", 32'(tx_en), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a = BASE + raddrs[$urandom_range(0, 15)];
      logic [31:0] d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      int op = $urandom_range(0, 3);
      sw = 8'($urandom);
      if (n == 300) do_reset();
      cyc(op == 1 || op == 3, op == 2, a, d, $urandom_range(0, 2) == 0, 8'($urandom),
          1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/periph_mmio_v2.md
Name: periph_mmio_v2

Overview:
Parametrised memory-mapped peripheral block on the CPU data bus. It is the next generation of the single-timer LED/switch/7-seg/UART register block. New in this generation:
- NUM_TIMERS independent reload timers, with a combined interrupt.
- Configurable GPIO widths.
- An RX byte FIFO with occupancy and sticky-overflow status, replacing the single RX holding register.
- Pop-on-read of RX data.

Parameters:
BASE_ADDR, 32'h40000000, base byte address of the register window
NUM_TIMERS, 2, number of timer channels (1..4)
LED_W, 8, LED output width (1..32)
SW_W, 8, switch input width (1..32)
DIGI_W, 12, 7-segment drive width (1..32)
RX_DEPTH, 4, RX FIFO depth in bytes (power of 2, 2..16)
TX_HOLD, 326, cycles tx_en stays high per transmit request

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd  in  1  bus read strobe
wr  in  1  bus write strobe
addr  in  32  byte address
wdata  in  32  write data
rdata  out  32  read data (combinational)
led  out  LED_W  LED drive
switch  in  SW_W  switch inputs
digi  out  DIGI_W  7-segment drive
irqout  out  1  OR of all timer pending bits
tx_en  out  1  UART transmit request
tx_data  out  8  byte to transmit (= TXD register)
tx_status  in  1  1 = transmitter idle/ready
rx_status  in  1  1-cycle pulse: rx_data valid
rx_data  in  8  received byte

Behaviour:
- One clock: clk. Reset is synchronous and active-high, on port reset. All state updates on posedge clk; reset has priority over everything.
- Reset values: all TH/TL/TCON = 0; led = 0; digi = 0; TXD = 0; tx_en = 0; tx counter = 0; FIFO empty (read/write pointers and count = 0); overflow = 0; irqout = 0.
- Register offsets from BASE_ADDR:
  - Timer i (i < NUM_TIMERS), base 0x10*i: +0x0 TH, +0x4 TL, +0x8 TCON[2:0]. TCON bit0 = enable, bit1 = irq enable, bit2 = pending.
  - 0x40 LED (RW), 0x44 SWITCH (RO), 0x48 DIGI (RW), 0x4C TXD (RW, 8b), 0x50 RXD (RO, pop), 0x54 USTAT.
  - USTAT read: bit0 = rx non-empty, bit1 = overflow, bit2 = tx_en, bits[8:4] = FIFO count. USTAT write: wdata bit1 = 1 clears overflow; all other bits ignored.
- Readback: narrower registers are zero-extended. Unmapped offsets, timer slots >= NUM_TIMERS, and addresses outside the window read 0 and ignore writes. rdata = 0 whenever rd = 0.
- Timers, each cycle when enable = 1:
  - If TL == 32'hFFFFFFFF: TL <= TH, and pending <= 1 if irq enable = 1.
  - Otherwise TL <= TL + 1.
  - Enable = 0 freezes TL.
  - A bus write to TL or TCON in the same cycle overrides the timer update, including pending set. A TCON write replaces all 3 bits, so pending is cleared by writing 0 to bit2.
- irqout = OR of pending over all timers (combinational from registers).
- TX request:
  - A write to 0x4C always latches wdata[7:0] into TXD and clears the counter.
  - tx_en <= tx_status at that write. If tx_status = 0, the request is dropped and tx_en = 0.
  - While tx_en = 1 the counter increments. tx_en falls once the counter reaches TX_HOLD-1, so tx_en is high exactly TX_HOLD cycles, starting the cycle after the write.
  - A write during an active request restarts the TX_HOLD window.
- RX FIFO:
  - rx_status = 1 pushes rx_data.
  - A read of 0x50 returns the head byte combinationally (0 if empty). If the FIFO is non-empty, the pop occurs on that clock edge.
  - Empty pop: returns 0, no state change.
  - Push when full with no pop: byte dropped, overflow <= 1 (sticky).
  - Simultaneous push and pop when full: both occur, no overflow.
  - Simultaneous push and pop when empty: the read returns 0 and the byte is stored.
  - Pointers wrap modulo RX_DEPTH.
- Reset asserted mid-transmit or mid-count: all state returns to its reset value on that edge.

Test Plan:
- Timer0 TH = 32'hFFFFFFFD, TL = 32'hFFFFFFFE, TCON = 3'b011 -> pending set 2 cycles later, TL reloads 32'hFFFFFFFD; irqout = 1. Write TCON = 3'b011 -> irqout = 0. Timer1 stays idle throughout.
- Timer1 pending set and a CPU write TCON = 3'b001 in the same cycle -> TCON reads 1, irqout = 0.
- Write TXD = 8'hA5 with tx_status = 1 -> tx_data = A5, tx_en high exactly 326 cycles. Repeat with tx_status = 0 -> tx_en stays 0.
- Push 5 bytes 01..05 with RX_DEPTH = 4 -> USTAT count = 4, overflow = 1. Reads return 01, 02, 03, 04, then 0. Write USTAT bit1 = 1 -> overflow = 0.
- FIFO full; rx_status pulse with 8'h77 in the same cycle as an RXD read -> read returns the head byte, count stays 4, no overflow, 77 is last out.
- LED write 32'h1FF with LED_W = 8 -> led = FF, readback 32'hFF. Read of offset 0x58 and of timer slot 3 -> 0. Reset asserted during an active TX -> tx_en = 0 next cycle.
